bitstream_accum: RTL and testbench

BITSTREAM_ACCUM -- requirements
Module: bitstream_accum

---
 rtl/bitstream_accum_if.sv | 13 +
 rtl/bitstream_accum.sv | 47 ++++
 tb/tb_bitstream_accum.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/bitstream_accum_if.sv
// bitstream_accum_if: control, bitstream and result handshake bundle for bitstream_accum
interface bitstream_accum_if #(parameter int WIDTH = 8);
    logic start;
    logic abort;
    logic in;
    logic in_valid;
    logic busy;
    logic out_valid;
    logic out_ready;
    logic [WIDTH:0] out;
    modport master (output start, abort, in, in_valid, out_ready, input busy, out_valid, out);
    modport slave (input start, abort, in, in_valid, out_ready, output busy, out_valid, out);
endinterface

// File: rtl/bitstream_accum.sv
// bitstream_accum: counts ones of a unary bitstream over a window of 2^WIDTH valid samples
module bitstream_accum #(parameter int WIDTH = 8) (
    input logic clk,
    input logic rst,
    bitstream_accum_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    logic [1:0] state;
    logic [WIDTH:0] cnt;
    logic [WIDTH-1:0] len;
    always_ff @(posedge clk) begin
        if (rst || bus.abort) begin
            state <= IDLE;
            cnt <= '0;
            len <= '0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    state <= RUN;
                    cnt <= '0;
                    len <= '0;
                end
                RUN: if (bus.in_valid) begin
                    cnt <= cnt + (WIDTH+1)'(bus.in);
                    len <= len + WIDTH'(1);
                    if (&len) state <= DONE;
                end
                DONE: if (bus.out_ready) begin
                    // a start on the handshake edge opens the next window with no idle cycle
                    state <= bus.start ? RUN : IDLE;
                    if (bus.start) begin
                        cnt <= '0;
                        len <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
    always_comb begin
        bus.busy = state == RUN;
        bus.out_valid = state == DONE;
        bus.out = state == DONE ? cnt : '0;
    end
endmodule

// File: tb/tb_bitstream_accum.sv
// tb_bitstream_accum: table-driven and directed checks of bitstream_accum with WIDTH=4
module tb_bitstream_accum;
    logic clk = 1'b0;
    logic rst;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    bitstream_accum_if #(.WIDTH(4)) bus();
    bitstream_accum #(.WIDTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));
    typedef struct packed {
        logic rs, s, a, d, v, r, eb, ev;
        logic [4:0] eo;
    } vec_t;
    vec_t tbl [19];
    function automatic vec_t mk(input int rs, s, a, d, v, r, eb, ev, eo);
        mk = '{rs: rs[0], s: s[0], a: a[0], d: d[0], v: v[0], r: r[0], eb: eb[0], ev: ev[0], eo: eo[4:0]};
    endfunction
    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask
    task automatic step(input logic rs, s, a, d, v, r);
        rst = rs;
        bus.start = s;
        bus.abort = a;
        bus.in = d;
        bus.in_valid = v;
        bus.out_ready = r;
        @(posedge clk);
        #1;
    endtask
    task automatic chk_out(input string nm, input int eb, input int ev, input int eo);
        chk({nm, ".busy"}, int'(bus.busy), eb);
        chk({nm, ".out_valid"}, int'(bus.out_valid), ev);
        chk({nm, ".out"}, int'(bus.out), eo);
    endtask
    // sixteen back-to-back valid samples, lsb first; out_valid must rise right after the last one
    task automatic feed(input string nm, input logic [15:0] bits);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b0, 1'b0, bits[i], 1'b1, 1'b0);
            chk({nm, ".busy"}, int'(bus.busy), i < 15 ? 1 : 0);
            chk({nm, ".out_valid"}, int'(bus.out_valid), i == 15 ? 1 : 0);
        end
    endtask
    initial begin
        int edges;
        int seen_valid;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.in = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        tbl[0]  = mk(1,0,0,0,0,0, 0,0,0);
        tbl[1]  = mk(0,0,0,0,0,0, 0,0,0);
        tbl[2]  = mk(0,1,1,0,0,0, 0,0,0);
        tbl[3]  = mk(0,0,1,0,0,0, 0,0,0);
        tbl[4]  = mk(0,0,0,1,1,1, 0,0,0);
        tbl[5]  = mk(0,1,0,0,0,0, 1,0,0);
        tbl[6]  = mk(0,0,0,1,1,0, 1,0,0);
        tbl[7]  = mk(0,0,0,1,0,0, 1,0,0);
        tbl[8]  = mk(0,1,0,1,1,0, 1,0,0);
        tbl[9]  = mk(0,0,1,1,1,0, 0,0,0);
        tbl[10] = mk(1,1,0,0,0,0, 0,0,0);
        tbl[11] = mk(0,1,0,0,0,0, 1,0,0);
        for (int i = 12; i < 17; i++) tbl[i] = mk(0,0,0,1,1,0, 1,0,0);
        tbl[17] = mk(1,0,0,1,1,1, 0,0,0);
        tbl[18] = mk(0,0,0,0,0,0, 0,0,0);
        for (int i = 0; i < 19; i++) begin
            step(tbl[i].rs, tbl[i].s, tbl[i].a, tbl[i].d, tbl[i].v, tbl[i].r);
            chk_out($sformatf("tbl%0d", i), int'(tbl[i].eb), int'(tbl[i].ev), int'(tbl[i].eo));
        end
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        feed("ones", 16'hFFFF);
        chk_out("ones_done", 0, 1, 16);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_out("ones_hs", 0, 0, 0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        feed("alt", 16'h5555);
        chk_out("alt_done", 0, 1, 8);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_out("alt_hs", 0, 0, 0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        feed("zeros", 16'h0000);
        chk_out("zeros_done", 0, 1, 0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        chk_out("done_abort", 0, 0, 0);
        // seven stalls with in=1 interleaved among sixteen ones
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        edges = 0;
        for (int i = 0; i < 16; i++) begin
            if (i > 0 && i < 8) begin
                step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
                edges++;
                chk("stall.out_valid", int'(bus.out_valid), 0);
            end
            step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
            edges++;
            chk("stall_sample.out_valid", int'(bus.out_valid), i == 15 ? 1 : 0);
        end
        chk("stall_edges", edges, 23);
        chk_out("stall_done", 0, 1, 16);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        feed("bp", 16'hFFFF);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, i[1], 1'b0, i[0], 1'b1, 1'b0);
            chk_out($sformatf("bp_hold%0d", i), 0, 1, 16);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_out("b2b", 1, 0, 0);
        feed("win2", 16'h000F);
        chk_out("win2_done", 0, 1, 4);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_out("win2_hs", 0, 0, 0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        seen_valid = 0;
        for (int i = 0; i < 9; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
            seen_valid |= int'(bus.out_valid);
        end
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        seen_valid |= int'(bus.out_valid);
        chk_out("abort_run", 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
            seen_valid |= int'(bus.out_valid);
        end
        chk("abort_no_pulse", seen_valid, 0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        feed("post_abort", 16'hFFFF);
        chk_out("post_abort_done", 0, 1, 16);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_out("done_rst", 0, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
